// File: rtl/otter_pc_redirect_ctrl.sv
// otter_pc_redirect_ctrl
// Owns the fetch PC. Each fetch handshake advances it by 4. Branches and
// jumps resolved in execute redirect it, and so do trap entry and mret.
// When imem is busy, the redirect target is parked in pend_addr_reg.
module otter_pc_redirect_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        ex_valid,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic        ex_branch,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] jal_addr,
  input  logic [31:0] jalr_addr,
  input  logic [31:0] branch_addr,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mepc,
  output logic [31:0] pc,
  output logic        flush,
  output logic        redirect_pending,
  output logic        misalign,
  output logic [31:0] redirect_cnt
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_addr_reg, pend_addr_next;
  logic [31:0] cnt_reg, cnt_next;

  logic        branch_cond;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] redirect_target;
  logic        accept;
  logic        flush_int;
  logic        pending_int;
  logic        misalign_int;

  // Branch condition evaluation; the reserved codes 010/011 never take.
  always_comb begin
    branch_cond = 1'b0;
    case (ex_funct3)
      3'b000:  branch_cond = (ex_rs1 == ex_rs2);
      3'b001:  branch_cond = (ex_rs1 != ex_rs2);
      3'b100:  branch_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  branch_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  branch_cond = (ex_rs1 <  ex_rs2);
      3'b111:  branch_cond = (ex_rs1 >= ex_rs2);
      default: branch_cond = 1'b0;
    endcase
  end

  // Execute-stage redirect decision and target selection. JALR clears bit 0.
  always_comb begin
    ex_taken  = ex_valid & (ex_jal | ex_jalr | (ex_branch & branch_cond));
    ex_target = branch_addr;
    if (ex_jal)
      ex_target = jal_addr;
    else if (ex_jalr)
      ex_target = {jalr_addr[31:1], 1'b0};
  end

  // Next-state logic: request priority is trap > mret > EX > sequential.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    pend_addr_next  = pend_addr_reg;
    cnt_next        = cnt_reg;
    redirect_target = pend_addr_reg;
    accept          = 1'b0;
    flush_int       = 1'b0;
    pending_int     = 1'b0;
    misalign_int    = 1'b0;

    unique case (state_reg)
      ST_RUN: begin
        if (trap_req) begin
          accept          = 1'b1;
          redirect_target = trap_vec;
        end else if (mret_req) begin
          accept          = 1'b1;
          redirect_target = mepc;
        end else if (ex_taken) begin
          // A misaligned EX target is dropped; the PC keeps sequencing.
          if (ex_target[1:0] != 2'b00) begin
            misalign_int = 1'b1;
          end else begin
            accept          = 1'b1;
            redirect_target = ex_target;
          end
        end

        if (accept) begin
          flush_int = 1'b1;
          cnt_next  = cnt_reg + 32'd1;
          if (fetch_ready) begin
            pc_next = redirect_target;
          end else begin
            // The PC holds so imem never sees its address change mid-access.
            pend_addr_next = redirect_target;
            state_next     = ST_PEND;
          end
        end else if (fetch_ready) begin
          pc_next = pc_reg + 32'd4;
        end
      end

      ST_PEND: begin
        // EX requests are ignored here: that slot is on the wrong path.
        flush_int   = 1'b1;
        pending_int = 1'b1;
        if (trap_req) begin
          accept          = 1'b1;
          redirect_target = trap_vec;
        end else if (mret_req) begin
          accept          = 1'b1;
          redirect_target = mepc;
        end

        if (accept) begin
          cnt_next       = cnt_reg + 32'd1;
          pend_addr_next = redirect_target;
        end

        if (fetch_ready) begin
          pc_next    = redirect_target;
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State registers, cleared asynchronously so the first fetch is RESET_VEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      pc_reg        <= RESET_VEC;
      pend_addr_reg <= 32'h0000_0000;
      cnt_reg       <= 32'h0000_0000;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pend_addr_reg <= pend_addr_next;
      cnt_reg       <= cnt_next;
    end
  end

  // The pulse outputs are forced low while reset is held, because their
  // request inputs may still be active during that time.
  always_comb begin
    pc               = pc_reg;
    redirect_cnt     = cnt_reg;
    flush            = rst_n & flush_int;
    redirect_pending = rst_n & pending_int;
    misalign         = rst_n & misalign_int;
  end

endmodule

// File: tb/tb_otter_pc_redirect_ctrl.sv
// tb_otter_pc_redirect_ctrl
// The bench runs directed scenarios with literal expectations, then
// randomized traffic. A behavioural model checks the DUT on every falling edge.
module tb_otter_pc_redirect_ctrl;

  localparam logic [31:0] RVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        ex_valid = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0, ex_branch = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_rs1 = 0, ex_rs2 = 0;
  logic [31:0] jal_addr = 0, jalr_addr = 0, branch_addr = 0;
  logic        trap_req = 1'b0, mret_req = 1'b0;
  logic [31:0] trap_vec = 0, mepc = 0;
  logic [31:0] pc, redirect_cnt;
  logic        flush, redirect_pending, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  otter_pc_redirect_ctrl #(.RESET_VEC(RVEC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .ex_valid(ex_valid), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .jal_addr(jal_addr), .jalr_addr(jalr_addr), .branch_addr(branch_addr),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req), .mepc(mepc),
    .pc(pc), .flush(flush), .redirect_pending(redirect_pending),
    .misalign(misalign), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc = RVEC, m_pend_addr = 0, m_cnt = 0;
  bit          m_pending = 0;
  logic [31:0] n_pc, n_pend_addr, n_cnt;
  bit          n_pending;

  function automatic bit cond_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 0;
    endcase
  endfunction

  // Compare process: derive the expected outputs, then work out the next model state.
  always @(negedge clk) begin
    bit          acc, mis, taken, e_flush;
    logic [31:0] tgt, et;
    acc = 0; mis = 0; e_flush = 0; tgt = 0;
    n_pc = m_pc; n_pend_addr = m_pend_addr; n_cnt = m_cnt; n_pending = m_pending;
    if (!rst_n) begin
      n_pc = RVEC; n_pend_addr = 0; n_cnt = 0; n_pending = 0;
    end else if (!m_pending) begin
      taken = ex_valid && (ex_jal || ex_jalr || (ex_branch && cond_of(ex_funct3, ex_rs1, ex_rs2)));
      et = ex_jal ? jal_addr : ex_jalr ? (jalr_addr & 32'hFFFF_FFFE) : branch_addr;
      if (trap_req) begin acc = 1; tgt = trap_vec; end
      else if (mret_req) begin acc = 1; tgt = mepc; end
      else if (taken) begin
        if (et % 4 != 0) mis = 1;
        else begin acc = 1; tgt = et; end
      end
      e_flush = acc;
      if (acc) begin
        n_cnt = m_cnt + 1;
        if (fetch_ready) n_pc = tgt;
        else begin n_pending = 1; n_pend_addr = tgt; end
      end else if (fetch_ready) n_pc = m_pc + 4;
    end else begin
      e_flush = 1;
      tgt = trap_req ? trap_vec : mret_req ? mepc : m_pend_addr;
      if (trap_req || mret_req) begin n_cnt = m_cnt + 1; n_pend_addr = tgt; end
      if (fetch_ready) begin n_pc = tgt; n_pending = 0; end
    end
    check("model_pc", pc, m_pc);
    check("model_cnt", redirect_cnt, m_cnt);
    check("model_flush", {31'd0, flush}, {31'd0, e_flush});
    check("model_pending", {31'd0, redirect_pending}, {31'd0, m_pending && rst_n});
    check("model_misalign", {31'd0, misalign}, {31'd0, mis});
  end

  // Model state update on the clock edge, or at once when reset is asserted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RVEC; m_pend_addr = 0; m_cnt = 0; m_pending = 0;
    end else begin
      m_pc = n_pc; m_pend_addr = n_pend_addr; m_cnt = n_cnt; m_pending = n_pending;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    ex_valid = 0; ex_jal = 0; ex_jalr = 0; ex_branch = 0;
    trap_req = 0; mret_req = 0;
  endtask

  task automatic set_branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] t);
    ex_valid = 1; ex_branch = 1; ex_funct3 = f; ex_rs1 = a; ex_rs2 = b; branch_addr = t;
  endtask

  logic [31:0] rs_pool [0:4];

  initial begin
    rs_pool[0] = 32'h0; rs_pool[1] = 32'h1; rs_pool[2] = 32'hFFFF_FFFF;
    rs_pool[3] = 32'h8000_0000; rs_pool[4] = 32'h5;

    // Reset, then three fetch handshakes.
    #1 rst_n = 0;
    fetch_ready = 1;
    step(); step();
    rst_n = 1;
    #1;
    check("reset_pc", pc, 32'h100);
    check("reset_cnt", redirect_cnt, 32'h0);
    check("reset_flush", {31'd0, flush}, 32'd0);
    step(); check("seq_pc1", pc, 32'h104);
    step(); check("seq_pc2", pc, 32'h108);
    step(); check("seq_pc3", pc, 32'h10C);

    // BEQ taken, then BEQ not taken.
    set_branch(3'b000, 5, 5, 32'h200); #1;
    check("beq_flush", {31'd0, flush}, 32'd1);
    step(); clear_req(); #1;
    check("beq_pc", pc, 32'h200);
    check("beq_cnt", redirect_cnt, 32'd1);
    set_branch(3'b000, 5, 6, 32'h200); #1;
    check("beq_nt_flush", {31'd0, flush}, 32'd0);
    step(); clear_req(); #1;
    check("beq_nt_pc", pc, 32'h204);

    // BLT versus BLTU on the same operands.
    set_branch(3'b100, 32'hFFFF_FFFF, 1, 32'h500); #1;
    check("blt_flush", {31'd0, flush}, 32'd1);
    step(); clear_req(); #1;
    check("blt_pc", pc, 32'h500);
    check("blt_cnt", redirect_cnt, 32'd2);
    set_branch(3'b110, 32'hFFFF_FFFF, 1, 32'h600); #1;
    check("bltu_flush", {31'd0, flush}, 32'd0);
    step(); clear_req(); #1;
    check("bltu_pc", pc, 32'h504);

    // JALR while imem is busy for three cycles.
    fetch_ready = 0;
    ex_valid = 1; ex_jalr = 1; jalr_addr = 32'h301; #1;
    check("jalr_flush0", {31'd0, flush}, 32'd1);
    step(); clear_req(); #1;
    check("pend_pc1", pc, 32'h504);
    check("pend_flag1", {31'd0, redirect_pending}, 32'd1);
    check("pend_flush1", {31'd0, flush}, 32'd1);
    step();
    check("pend_pc2", pc, 32'h504);
    check("pend_flush2", {31'd0, flush}, 32'd1);
    step();
    fetch_ready = 1; #1;
    check("pend_pc3", pc, 32'h504);
    step();
    check("jalr_pc", pc, 32'h300);
    check("jalr_pending", {31'd0, redirect_pending}, 32'd0);
    check("jalr_cnt", redirect_cnt, 32'd3);

    // Misaligned JAL target.
    ex_valid = 1; ex_jal = 1; jal_addr = 32'h402; #1;
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_flush", {31'd0, flush}, 32'd0);
    step(); clear_req(); #1;
    check("mis_pc", pc, 32'h304);
    check("mis_cnt", redirect_cnt, 32'd3);
    check("mis_clear", {31'd0, misalign}, 32'd0);

    // A trap while a redirect is pending overwrites the parked target.
    fetch_ready = 0;
    ex_valid = 1; ex_jalr = 1; jalr_addr = 32'h301;
    step(); clear_req();
    trap_req = 1; trap_vec = 32'h80; #1;
    check("ptrap_pending", {31'd0, redirect_pending}, 32'd1);
    step(); trap_req = 0; #1;
    check("ptrap_cnt", redirect_cnt, 32'd5);
    check("ptrap_hold", pc, 32'h304);
    fetch_ready = 1;
    step();
    check("ptrap_pc", pc, 32'h80);

    // A trap and a taken BNE in the same cycle: the trap wins and counts once.
    trap_req = 1; trap_vec = 32'h80;
    set_branch(3'b001, 1, 2, 32'h600); #1;
    check("tb_flush", {31'd0, flush}, 32'd1);
    step(); clear_req(); #1;
    check("tb_pc", pc, 32'h80);
    check("tb_cnt", redirect_cnt, 32'd6);

    // The PC wraps from 0xFFFF_FFFC to 0.
    ex_valid = 1; ex_jal = 1; jal_addr = 32'hFFFF_FFFC;
    step(); clear_req(); #1;
    check("wrap_top", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_zero", pc, 32'h0);

    // Reset while a redirect is pending.
    fetch_ready = 0;
    ex_valid = 1; ex_jalr = 1; jalr_addr = 32'h301;
    step(); clear_req(); #1;
    check("rp_pending", {31'd0, redirect_pending}, 32'd1);
    rst_n = 0; #1;
    check("rp_pc", pc, 32'h100);
    check("rp_pending0", {31'd0, redirect_pending}, 32'd0);
    check("rp_cnt", redirect_cnt, 32'd0);
    step(); rst_n = 1; fetch_ready = 1; #1;
    check("rp_first", pc, 32'h100);
    step();
    check("rp_next", pc, 32'h104);

    // Randomized traffic, checked only by the model.
    for (int i = 0; i < 3000; i++) begin
      int cls;
      step();
      rst_n       = ($urandom_range(0, 299) != 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      cls         = $urandom_range(0, 3);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_jal      = (cls == 1);
      ex_jalr     = (cls == 2);
      ex_branch   = (cls == 3);
      ex_funct3   = 3'($urandom_range(0, 7));
      ex_rs1      = ($urandom_range(0, 1) != 0) ? rs_pool[$urandom_range(0, 4)] : $urandom;
      ex_rs2      = ($urandom_range(0, 1) != 0) ? rs_pool[$urandom_range(0, 4)] : $urandom;
      jal_addr    = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      jalr_addr   = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
      branch_addr = $urandom & (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      trap_req    = ($urandom_range(0, 15) == 0);
      mret_req    = ($urandom_range(0, 15) == 0);
      trap_vec    = $urandom;
      mepc        = $urandom;
    end
    step();
    rst_n = 1; clear_req();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
